// File: rtl/perf_bcd_pkg.sv
// perf_bcd_pkg: shared types and constants for the perf_bcd binary-to-BCD converter.
// Holds the FSM state enum, default sizing constants and the BCD scratch-width helper.
package perf_bcd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } perf_bcd_state_t;

  localparam int PERF_WIDTH  = 32;
  localparam int PERF_DIGITS = 6;

  // Number of BCD nibbles needed to hold any WIDTH-bit unsigned value.
  // log10(2) ~= 0.302, so WIDTH bits need at most WIDTH*0.302+1 decimal digits.
  function automatic int bcd_nibbles(input int width);
    return (width * 302) / 1000 + 1;
  endfunction

endpackage

// File: rtl/perf_bcd_if.sv
// perf_bcd_if: start/busy/done handshake and result bus of the perf_bcd converter.
// master = requester (wrapper / bench), slave = converter.
interface perf_bcd_if #(
  parameter int WIDTH  = 32,
  parameter int DIGITS = 6
);
  logic                  start;
  logic [WIDTH-1:0]      value;
  logic                  busy;
  logic                  done;
  logic [4*DIGITS-1:0]   digits;
  logic                  ovf;
  logic [DIGITS-1:0]     blank;

  modport master (
    output start, value,
    input  busy, done, digits, ovf, blank
  );

  modport slave (
    input  start, value,
    output busy, done, digits, ovf, blank
  );
endinterface

// File: rtl/perf_bcd_add3.sv
// bcd_add3: combinational double-dabble nibble corrector.
// Adds 3 to a nibble of 5 or more so the following left shift carries into the
// next decimal digit. Inputs are always <= 9, so the result fits in 4 bits.
module bcd_add3 (
  input  logic [3:0] nib,
  output logic [3:0] adj
);

  // Correct nibbles that would reach 10 or more after doubling.
  always_comb begin
    adj = (nib >= 4'd5) ? (nib + 4'd3) : nib;
  end

endmodule

// File: rtl/perf_bcd.sv
// perf_bcd: sequential binary-to-BCD converter (shift-and-add-3) for the TSP
// performance readout. One conversion takes WIDTH shift cycles plus a result cycle.
// Optional leading-zero blanking is enabled by defining PERF_BCD_BLANK_EN; without
// it the blank output is tied to zero.
module perf_bcd
  import perf_bcd_pkg::*;
#(
  parameter int WIDTH  = PERF_WIDTH,
  parameter int DIGITS = PERF_DIGITS
) (
  input  logic        clk,
  input  logic        rst,
  perf_bcd_if.slave   bus
);

  localparam int BCD_N = bcd_nibbles(WIDTH);
  // Scratch viewed with at least DIGITS nibbles so the result slice is always legal.
  localparam int PAD_N = (DIGITS > BCD_N) ? DIGITS : BCD_N;
  localparam int CW    = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_SHIFT = CW'(WIDTH - 1);

  perf_bcd_state_t       state_reg;
  logic [WIDTH-1:0]      bin_reg;
  logic [4*BCD_N-1:0]    bcd_reg;
  logic [CW-1:0]         cnt_reg;
  logic                  busy_reg;
  logic                  done_reg;
  logic [4*DIGITS-1:0]   digits_reg;
  logic                  ovf_reg;

  logic [4*BCD_N-1:0]    bcd_adj;
  logic [4*BCD_N-1:0]    bcd_next;
  logic [WIDTH-1:0]      bin_next;
  logic [4*PAD_N-1:0]    bcd_wide;
  logic                  ovf_next;
  logic [4*DIGITS-1:0]   digits_next;

  // Per-nibble add-3 correction applied before every shift.
  genvar gi;
  generate
    for (gi = 0; gi < BCD_N; gi++) begin : g_add3
      bcd_add3 u_add3 (
        .nib (bcd_reg[4*gi +: 4]),
        .adj (bcd_adj[4*gi +: 4])
      );
    end
  endgenerate

  // One double-dabble step: corrected scratch and binary shift left together.
  always_comb begin
    bcd_next = {bcd_adj[4*BCD_N-2:0], bin_reg[WIDTH-1]};
    bin_next = {bin_reg[WIDTH-2:0], 1'b0};
  end

  assign bcd_wide = (4*PAD_N)'(bcd_reg);

  // Saturate to all nines when any digit beyond the display is nonzero.
  always_comb begin
    ovf_next = 1'b0;
    for (int i = DIGITS; i < PAD_N; i++) begin
      if (bcd_wide[4*i +: 4] != 4'd0) begin
        ovf_next = 1'b1;
      end
    end
    digits_next = ovf_next ? {DIGITS{4'h9}} : bcd_wide[4*DIGITS-1:0];
  end

  // Control FSM with registered handshake and result outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= IDLE;
      bin_reg    <= '0;
      bcd_reg    <= '0;
      cnt_reg    <= '0;
      busy_reg   <= 1'b0;
      done_reg   <= 1'b0;
      digits_reg <= '0;
      ovf_reg    <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          busy_reg <= 1'b0;
          if (bus.start) begin
            bin_reg   <= bus.value;
            bcd_reg   <= '0;
            cnt_reg   <= '0;
            state_reg <= SHIFT;
          end
        end
        SHIFT: begin
          busy_reg <= 1'b1;
          bin_reg  <= bin_next;
          bcd_reg  <= bcd_next;
          cnt_reg  <= cnt_reg + 1'b1;
          if (cnt_reg == LAST_SHIFT) begin
            state_reg <= DONE;
          end
        end
        DONE: begin
          busy_reg   <= 1'b1;
          done_reg   <= 1'b1;
          digits_reg <= digits_next;
          ovf_reg    <= ovf_next;
          state_reg  <= IDLE;
        end
        default: begin
          state_reg <= IDLE;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy   = busy_reg;
  assign bus.done   = done_reg;
  assign bus.digits = digits_reg;
  assign bus.ovf    = ovf_reg;

`ifdef PERF_BCD_BLANK_EN
  localparam logic [DIGITS-1:0] BLANK_RST = {{(DIGITS-1){1'b1}}, 1'b0};

  // zero_above[i]: digit i and every higher digit of the new result are zero.
  logic [DIGITS:1]     zero_above;
  logic [DIGITS-1:0]   blank_next;
  logic [DIGITS-1:0]   blank_reg;

  assign zero_above[DIGITS] = 1'b1;
  generate
    for (gi = 1; gi < DIGITS; gi++) begin : g_blank
      assign zero_above[gi] = zero_above[gi+1] && (digits_next[4*gi +: 4] == 4'd0);
    end
  endgenerate

  // Digit 0 is never blanked so a zero result still shows "0".
  assign blank_next = ovf_next ? '0 : {zero_above[DIGITS-1:1], 1'b0};

  // Blank mask is refreshed together with the digits in the result cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      blank_reg <= BLANK_RST;
    end else if (state_reg == DONE) begin
      blank_reg <= blank_next;
    end
  end

  assign bus.blank = blank_reg;
`else
  assign bus.blank = '0;
`endif

endmodule

// File: tb/tb_perf_bcd.sv
// tb_perf_bcd: directed self-checking bench for perf_bcd.
// A cycle-level reference (acceptance timeline + decimal arithmetic) is compared
// with the DUT every cycle; directed vectors add literal expectations.
module tb_perf_bcd;
  import perf_bcd_pkg::*;

  localparam int W = PERF_WIDTH;
  localparam int D = PERF_DIGITS;
`ifdef PERF_BCD_BLANK_EN
  localparam logic [D-1:0] BLANK_RST = {{(D-1){1'b1}}, 1'b0};
  localparam bit BLANK_ON = 1'b1;
`else
  localparam logic [D-1:0] BLANK_RST = '0;
  localparam bit BLANK_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  perf_bcd_if #(.WIDTH(W), .DIGITS(D)) bus ();

  perf_bcd #(.WIDTH(W), .DIGITS(D)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic logic e_ovf_of(input longint v);
    return v > 64'd999999;
  endfunction

  function automatic logic [4*D-1:0] e_dig_of(input longint v);
    logic [4*D-1:0] r;
    longint t;
    r = '0;
    if (e_ovf_of(v)) begin
      for (int i = 0; i < D; i++) r[4*i +: 4] = 4'd9;
    end else begin
      t = v;
      for (int i = 0; i < D; i++) begin
        r[4*i +: 4] = 4'(t % 10);
        t = t / 10;
      end
    end
    return r;
  endfunction

  function automatic logic [D-1:0] e_blank_of(input longint v);
    logic [D-1:0] r;
    longint p;
    r = '0;
    if (BLANK_ON && !e_ovf_of(v)) begin
      p = 1;
      for (int i = 1; i < D; i++) begin
        p = p * 10;
        r[i] = ((v / p) == 0);
      end
    end
    return r;
  endfunction

  int              m_age;
  longint          m_val;
  logic            e_busy, e_done, e_ovf;
  logic [4*D-1:0]  e_digits;
  logic [D-1:0]    e_blank;

  // Reference timeline: age counts edges since acceptance; result appears at age W+1.
  always @(posedge clk) begin
    if (rst) begin
      m_age    <= -1;
      e_busy   <= 1'b0;
      e_done   <= 1'b0;
      e_digits <= '0;
      e_ovf    <= 1'b0;
      e_blank  <= BLANK_RST;
    end else begin
      e_done <= 1'b0;
      if (m_age < 0) begin
        e_busy <= 1'b0;
        if (bus.start) begin
          m_age <= 0;
          m_val <= longint'(bus.value);
        end
      end else if (m_age < W) begin
        m_age  <= m_age + 1;
        e_busy <= 1'b1;
      end else begin
        e_busy   <= 1'b1;
        e_done   <= 1'b1;
        e_digits <= e_dig_of(m_val);
        e_ovf    <= e_ovf_of(m_val);
        e_blank  <= e_blank_of(m_val);
        m_age    <= -1;
      end
    end
  end

  // ---------------- checking ----------------
  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
    end
  endtask

  // Advance one cycle and compare every DUT output against the reference.
  task automatic tick();
    @(negedge clk);
    chk("cyc_busy",   64'(bus.busy),   64'(e_busy));
    chk("cyc_done",   64'(bus.done),   64'(e_done));
    chk("cyc_digits", 64'(bus.digits), 64'(e_digits));
    chk("cyc_ovf",    64'(bus.ovf),    64'(e_ovf));
    chk("cyc_blank",  64'(bus.blank),  64'(e_blank));
  endtask

  typedef struct {
    logic [31:0] v;
    logic [23:0] dig;
    logic        ovf;
    logic [5:0]  blk_en;
  } vec_t;

  vec_t vecs [9] = '{
    '{32'd0,          24'h000000, 1'b0, 6'b111110},
    '{32'd123456,     24'h123456, 1'b0, 6'b000000},
    '{32'd999999,     24'h999999, 1'b0, 6'b000000},
    '{32'd1000000,    24'h999999, 1'b1, 6'b000000},
    '{32'hFFFFFFFF,   24'h999999, 1'b1, 6'b000000},
    '{32'd42,         24'h000042, 1'b0, 6'b111100},
    '{32'd7,          24'h000007, 1'b0, 6'b111110},
    '{32'd1000,       24'h001000, 1'b0, 6'b110000},
    '{32'd100000,     24'h100000, 1'b0, 6'b000000}
  };

  // One conversion: pulse start, wait (bounded) for done, check literal results.
  task automatic run_conv(input vec_t vv);
    int k;
    logic [5:0] exp_blk;
    exp_blk = BLANK_ON ? vv.blk_en : 6'b000000;
    bus.start = 1'b1;
    bus.value = vv.v;
    tick();
    bus.start = 1'b0;
    bus.value = $urandom;
    k = 1;
    while (!bus.done && k < 60) begin
      tick();
      k++;
    end
    $display("conv value=%0d done_after=%0d digits=%h ovf=%0b blank=%b",
             vv.v, k, bus.digits, bus.ovf, bus.blank);
    chk("latency", 64'(k),          64'd34);
    chk("digits",  64'(bus.digits), 64'(vv.dig));
    chk("ovf",     64'(bus.ovf),    64'(vv.ovf));
    chk("blank",   64'(bus.blank),  64'(exp_blk));
    tick();
    chk("busy_after_done", 64'(bus.busy), 64'd0);
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog no finish by %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int ndone;
    int kdone;
    logic [23:0] dig_at_done;
    logic busy35;

    rst = 1'b1;
    bus.start = 1'b0;
    bus.value = '0;
    repeat (3) tick();
    chk("rst_busy",   64'(bus.busy),   64'd0);
    chk("rst_done",   64'(bus.done),   64'd0);
    chk("rst_digits", 64'(bus.digits), 64'd0);
    chk("rst_ovf",    64'(bus.ovf),    64'd0);
    chk("rst_blank",  64'(bus.blank),  64'(BLANK_RST));
    rst = 1'b0;
    tick();

    foreach (vecs[i]) run_conv(vecs[i]);

    // Second start five cycles into a conversion must be ignored.
    ndone = 0; kdone = 0; dig_at_done = '0; busy35 = 1'b1;
    for (int k = 1; k <= 45; k++) begin
      bus.start = (k == 1) || (k == 6);
      bus.value = (k == 6) ? 32'd31415 : 32'd271828;
      tick();
      if (bus.done) begin
        ndone++;
        kdone = k;
        dig_at_done = bus.digits;
      end
      if (k == 35) busy35 = bus.busy;
    end
    bus.start = 1'b0;
    $display("double_start dones=%0d at=%0d digits=%h busy35=%0b", ndone, kdone, dig_at_done, busy35);
    chk("dbl_ndone",  64'(ndone),       64'd1);
    chk("dbl_kdone",  64'(kdone),       64'd34);
    chk("dbl_digits", 64'(dig_at_done), 64'h271828);
    chk("dbl_busy35", 64'(busy35),      64'd0);
    tick();

    // Reset at T+10 (with a simultaneous start) aborts the conversion.
    for (int k = 1; k <= 11; k++) begin
      bus.start = (k == 1) || (k == 11);
      bus.value = 32'd5555;
      rst = (k == 11);
      tick();
    end
    bus.start = 1'b0;
    rst = 1'b0;
    $display("abort busy=%0b digits=%h ovf=%0b", bus.busy, bus.digits, bus.ovf);
    chk("abort_busy",   64'(bus.busy),   64'd0);
    chk("abort_digits", 64'(bus.digits), 64'd0);
    chk("abort_ovf",    64'(bus.ovf),    64'd0);
    ndone = 0;
    for (int k = 0; k < 40; k++) begin
      tick();
      if (bus.done) ndone++;
    end
    $display("abort dones_in_40=%0d", ndone);
    chk("abort_no_done", 64'(ndone), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
